// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC scan sequencer.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  localparam int unsigned SLOT_W = 3;
  localparam int unsigned DROP_W = 8;

  // LSB of a slot's channel field inside the packed channel map.
  function automatic int unsigned ch_map_lsb(input int unsigned slot, input int unsigned ch_w);
    return slot * ch_w;
  endfunction

endpackage

// File: rtl/adc_seq_accum.sv
// Per-slot accumulator array: add into, clear or read the addressed slot, or clear all slots.
module adc_seq_accum
  import adc_seq_pkg::*;
#(
  parameter int unsigned NumSlots = 4,
  parameter int unsigned AccW     = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_all_i,
  input  logic [SLOT_W-1:0] slot_i,
  input  logic              add_i,
  input  logic [AccW-1:0]   add_val_i,
  input  logic              clr_i,
  output logic [AccW-1:0]   rd_val_o
);

  logic [AccW-1:0] acc_q [NumSlots];
  logic [AccW-1:0] acc_d [NumSlots];

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      acc_d[i] = acc_q[i];
      if (clear_all_i || (clr_i && (slot_i == SLOT_W'(i)))) begin
        acc_d[i] = '0;
      end else if (add_i && (slot_i == SLOT_W'(i))) begin
        acc_d[i] = acc_q[i] + add_val_i;
      end
    end
  end

  always_comb begin
    rd_val_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (slot_i == SLOT_W'(i)) begin
        rd_val_o = acc_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scan controller for the modular ADC core: walks the slot list one command at a time, averages
// conversions per slot and streams results, with response checking, timeout and drop accounting.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned               NUM_SLOTS = 4,
  parameter int unsigned               CH_W      = 5,
  parameter int unsigned               DATA_W    = 12,
  parameter int unsigned               AVG_LOG2  = 2,
  parameter logic [NUM_SLOTS*CH_W-1:0] CH_MAP    = {5'd4, 5'd3, 5'd2, 5'd1},
  parameter int unsigned               TIMEOUT   = 255
) (
  input  logic              clock_clk,
  input  logic              reset_sink_reset,
  input  logic              enable,
  input  logic              clear_status,
  output logic              command_valid,
  output logic [CH_W-1:0]   command_channel,
  output logic              command_startofpacket,
  output logic              command_endofpacket,
  input  logic              command_ready,
  input  logic              response_valid,
  input  logic [CH_W-1:0]   response_channel,
  input  logic [DATA_W-1:0] response_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SLOT_W-1:0] out_slot,
  output logic [CH_W-1:0]   out_channel,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              flag_overflow,
  output logic              flag_mismatch,
  output logic              flag_timeout,
  output logic [DROP_W-1:0] drop_count
);

  localparam int unsigned       AccW      = DATA_W + AVG_LOG2;
  localparam int unsigned       RoundW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned       TmrW      = $clog2(TIMEOUT + 1);
  localparam logic [RoundW-1:0] LastRound = RoundW'((1 << AVG_LOG2) - 1);
  localparam logic [SLOT_W-1:0] LastSlot  = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [TmrW-1:0]   TmrLast   = TmrW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [RoundW-1:0] round_q, round_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;

  logic              out_valid_q, out_valid_d;
  logic [SLOT_W-1:0] out_slot_q, out_slot_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              mismatch_q, mismatch_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d, drop_base;

  logic [CH_W-1:0]   exp_ch;
  logic              in_wait, resp_ok, resp_bad, tmo, slot_done, last_round;
  logic              emit, load, drop, acc_add, clear_all;
  logic [AccW-1:0]   acc_rd, sum;
  logic [DATA_W-1:0] result;

  function automatic logic [CH_W-1:0] slot_channel(input logic [SLOT_W-1:0] s);
    return CH_MAP[ch_map_lsb(int'(s), CH_W) +: CH_W];
  endfunction

  always_comb begin
    exp_ch     = slot_channel(slot_q);
    in_wait    = (state_q == StWait);
    resp_ok    = in_wait && response_valid && (response_channel == exp_ch);
    resp_bad   = in_wait && response_valid && (response_channel != exp_ch);
    tmo        = in_wait && !response_valid && (tmr_q == TmrLast);
    slot_done  = in_wait && (response_valid || (tmr_q == TmrLast));
    last_round = (round_q == LastRound);
    acc_add    = resp_ok && !last_round;
    emit       = slot_done && last_round;
    // Final round: the average includes this cycle's sample, which never lands in the array.
    sum        = acc_rd + (resp_ok ? AccW'(response_data) : '0);
    result     = DATA_W'(sum >> AVG_LOG2);
    load       = emit && (!out_valid_q || out_ready);
    drop       = emit && !load;
  end

  adc_seq_accum #(
    .NumSlots (NUM_SLOTS),
    .AccW     (AccW)
  ) u_accum (
    .clk_i       (clock_clk),
    .rst_i       (reset_sink_reset),
    .clear_all_i (clear_all),
    .slot_i      (slot_q),
    .add_i       (acc_add),
    .add_val_i   (AccW'(response_data)),
    .clr_i       (emit),
    .rd_val_o    (acc_rd)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    round_d   = round_q;
    tmr_d     = tmr_q;
    clear_all = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StIssue;
      end
      StIssue: begin
        if (command_ready) begin
          state_d = StWait;
          tmr_d   = '0;
        end else if (!enable) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (slot_done) begin
          state_d = enable ? StIssue : StIdle;
          if (slot_q == LastSlot) begin
            slot_d  = '0;
            round_d = last_round ? '0 : round_q + 1'b1;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Any return to idle discards the partial scan; a pending output is left alone.
    if ((state_q != StIdle) && (state_d == StIdle)) begin
      clear_all = 1'b1;
      slot_d    = '0;
      round_d   = '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_slot_d  = out_slot_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_slot_d  = slot_q;
      out_ch_d    = exp_ch;
      out_data_d  = result;
    end
  end

  // A flag event in the same cycle as clear_status wins over the clear.
  always_comb begin
    mismatch_d = (clear_status ? 1'b0 : mismatch_q) | resp_bad;
    timeout_d  = (clear_status ? 1'b0 : timeout_q) | tmo;
    overflow_d = (clear_status ? 1'b0 : overflow_q) | drop;
    drop_base  = clear_status ? '0 : drop_q;
    drop_d     = (drop && (drop_base != '1)) ? drop_base + 1'b1 : drop_base;
  end

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      state_q     <= StIdle;
      slot_q      <= '0;
      round_q     <= '0;
      tmr_q       <= '0;
      out_valid_q <= 1'b0;
      out_slot_q  <= '0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      round_q     <= round_d;
      tmr_q       <= tmr_d;
      out_valid_q <= out_valid_d;
      out_slot_q  <= out_slot_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      mismatch_q  <= mismatch_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  assign command_valid         = (state_q == StIssue);
  assign command_channel       = command_valid ? exp_ch : '0;
  assign command_startofpacket = command_valid && (slot_q == '0);
  assign command_endofpacket   = command_valid && (slot_q == LastSlot);
  assign out_valid             = out_valid_q;
  assign out_slot              = out_slot_q;
  assign out_channel           = out_ch_q;
  assign out_data              = out_data_q;
  assign busy                  = (state_q != StIdle);
  assign flag_overflow         = overflow_q;
  assign flag_mismatch         = mismatch_q;
  assign flag_timeout          = timeout_q;
  assign drop_count            = drop_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: an ADC responder plus a slot/round averaging model and scoreboard.
module tb_adc_scan_sequencer;

  localparam int NS = 4;
  localparam int AL = 2;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset, enable, clear_status;
  logic        command_valid, command_startofpacket, command_endofpacket, command_ready;
  logic [4:0]  command_channel, response_channel, out_channel;
  logic        response_valid, out_valid, out_ready, busy;
  logic [11:0] response_data, out_data;
  logic [2:0]  out_slot;
  logic        flag_overflow, flag_mismatch, flag_timeout;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  adc_scan_sequencer #(
    .NUM_SLOTS (4),
    .CH_W      (5),
    .DATA_W    (12),
    .AVG_LOG2  (AL),
    .CH_MAP    ({5'd4, 5'd3, 5'd2, 5'd1}),
    .TIMEOUT   (TO)
  ) dut (
    .clock_clk             (clk),
    .reset_sink_reset      (reset),
    .enable                (enable),
    .clear_status          (clear_status),
    .command_valid         (command_valid),
    .command_channel       (command_channel),
    .command_startofpacket (command_startofpacket),
    .command_endofpacket   (command_endofpacket),
    .command_ready         (command_ready),
    .response_valid        (response_valid),
    .response_channel      (response_channel),
    .response_data         (response_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_slot              (out_slot),
    .out_channel           (out_channel),
    .out_data              (out_data),
    .busy                  (busy),
    .flag_overflow         (flag_overflow),
    .flag_mismatch         (flag_mismatch),
    .flag_timeout          (flag_timeout),
    .drop_count            (drop_count)
  );

  typedef struct {
    int slot;
    int ch;
    int data;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  int   ch_tab [NS] = '{1, 2, 3, 4};
  int   m_sum [NS];
  int   m_slot, m_round, m_drop, rk;
  bit   m_mm, m_to, m_ov, m_hold, m_held_valid, mon_en;
  res_t m_held, mon_r;
  res_t exp_q [$];
  int   obs_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset_scan();
    for (int i = 0; i < NS; i++) m_sum[i] = 0;
    m_slot  = 0;
    m_round = 0;
  endtask

  task automatic m_clear();
    m_mm   = 0;
    m_to   = 0;
    m_ov   = 0;
    m_drop = 0;
  endtask

  task automatic m_full_reset();
    m_reset_scan();
    m_clear();
    m_hold       = 0;
    m_held_valid = 0;
    exp_q.delete();
  endtask

  // kind: 0 = good sample, 1 = wrong channel, 2 = no response (timeout).
  task automatic m_complete(input int kind, input int data);
    res_t r;
    int   n;
    n = 1 << AL;
    if (kind == 0) m_sum[m_slot] += data;
    else if (kind == 1) m_mm = 1;
    else m_to = 1;
    if (m_round == n - 1) begin
      r.slot = m_slot;
      r.ch   = ch_tab[m_slot];
      r.data = m_sum[m_slot] / n;
      m_sum[m_slot] = 0;
      if (!m_hold) exp_q.push_back(r);
      else if (!m_held_valid) begin
        m_held       = r;
        m_held_valid = 1;
      end else begin
        m_ov = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_slot++;
    if (m_slot == NS) begin
      m_slot  = 0;
      m_round = (m_round + 1) % n;
    end
  endtask

  task automatic wait_cmd();
    int n;
    n = 0;
    while (command_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_wait", command_valid, 1);
  endtask

  task automatic serve(input int kind, input int data, input int rdly, input int wdly,
                       input bit drop_en);
    wait_cmd();
    chk("cmd_channel", command_channel, ch_tab[m_slot]);
    chk("cmd_sop", command_startofpacket, (m_slot == 0));
    chk("cmd_eop", command_endofpacket, (m_slot == NS - 1));
    repeat (rdly) @(negedge clk);
    command_ready = 1;
    @(negedge clk);
    command_ready = 0;
    if (drop_en) enable = 0;
    if (kind == 2) begin
      clear_status = 1;
      m_clear();
      @(negedge clk);
      clear_status = 0;
      repeat (13) @(negedge clk);
      chk("timeout_early", flag_timeout, 0);
      m_complete(2, 0);
      @(negedge clk);
      chk("timeout_15th", flag_timeout, 1);
    end else begin
      repeat (wdly) @(negedge clk);
      response_valid   = 1;
      response_channel = (kind == 1) ? 5'd7 : 5'(ch_tab[m_slot]);
      response_data    = 12'(data);
      m_complete(kind, data);
      @(negedge clk);
      response_valid = 0;
    end
    if (drop_en) begin
      chk("idle_after_wait", busy, 0);
      chk("no_cmd_after_wait", command_valid, 0);
      m_reset_scan();
      enable = 1;
    end
  endtask

  task automatic chk_flags();
    chk("flag_mismatch", flag_mismatch, m_mm);
    chk("flag_timeout", flag_timeout, m_to);
    chk("flag_overflow", flag_overflow, m_ov);
    chk("drop_count", drop_count, m_drop);
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset && out_valid && out_ready) begin
      obs_q.push_back(int'(out_data));
      chk("out_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_r = exp_q.pop_front();
        chk("out_slot", out_slot, mon_r.slot);
        chk("out_channel", out_channel, mon_r.ch);
        chk("out_data", out_data, mon_r.data);
      end
    end
  end

  initial begin
    reset = 1; enable = 0; clear_status = 0; command_ready = 0;
    response_valid = 0; response_channel = 0; response_data = 0;
    out_ready = 1; mon_en = 0;
    m_full_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_cmd_valid", command_valid, 0);
    chk("rst_cmd_channel", command_channel, 0);
    chk("rst_sop", command_startofpacket, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk_flags();

    // Ramp data 100*ch + round: averages are 100*ch + 1 after truncation.
    mon_en = 1;
    enable = 1;
    for (int i = 0; i < 16; i++) serve(0, 100 * ch_tab[m_slot] + m_round, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("ramp_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) chk("ramp_avg", obs_q[i], 100 * (i + 1) + 1);
    chk("ramp_drained", exp_q.size(), 0);
    chk_flags();

    // Random samples, delays, wrong channels, timeouts and enable drops during WAIT.
    for (int i = 0; i < 80; i++) begin
      rk = $urandom_range(11);
      serve((rk <= 8) ? 0 : ((rk <= 10) ? 1 : 2), $urandom_range(4095), $urandom_range(3),
            $urandom_range(5), ($urandom_range(15) == 0));
    end
    repeat (3) @(negedge clk);
    chk("rand_drained", exp_q.size(), 0);
    chk_flags();

    // enable dropped in ISSUE before the handshake.
    wait_cmd();
    enable = 0;
    @(negedge clk);
    chk("issue_abort_valid", command_valid, 0);
    chk("issue_abort_busy", busy, 0);
    m_reset_scan();

    // Output stalled: first result held, everything after it dropped, counter saturates.
    clear_status = 1;
    m_clear();
    @(negedge clk);
    clear_status = 0;
    mon_en = 0;
    out_ready = 0;
    m_hold = 1;
    enable = 1;
    for (int i = 0; i < 32; i++) serve(0, $urandom_range(4095), 0, 0, 0);
    @(negedge clk);
    chk("hold_valid", out_valid, 1);
    chk("hold_slot", out_slot, m_held.slot);
    chk("hold_channel", out_channel, m_held.ch);
    chk("hold_data", out_data, m_held.data);
    chk("drop_seven", drop_count, m_drop);
    chk_flags();
    for (int i = 0; i < 1000; i++) serve(0, $urandom_range(4095), 0, 0, 0);
    @(negedge clk);
    chk("hold_data_late", out_data, m_held.data);
    chk("drop_saturated", drop_count, m_drop);
    chk_flags();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    m_held_valid = 0;
    chk("hold_released", out_valid, 0);
    enable = 0;
    @(negedge clk);
    chk("hold_idle", busy, 0);
    m_reset_scan();
    m_hold = 0;
    out_ready = 1;
    mon_en = 1;

    // Reset while waiting on a response; the late response must be ignored.
    enable = 1;
    for (int i = 0; i < 6; i++) serve(0, $urandom_range(4095), 0, $urandom_range(2), 0);
    wait_cmd();
    command_ready = 1;
    @(negedge clk);
    command_ready = 0;
    reset = 1;
    enable = 0;
    @(negedge clk);
    reset = 0;
    response_valid = 1;
    response_channel = 5'(ch_tab[m_slot]);
    response_data = 12'hfff;
    @(negedge clk);
    response_valid = 0;
    m_full_reset();
    chk("late_busy", busy, 0);
    chk("late_out_valid", out_valid, 0);
    chk_flags();

    // Fresh scan after reset: averages must not include pre-reset samples.
    enable = 1;
    for (int i = 0; i < 16; i++) serve(0, $urandom_range(4095), $urandom_range(2),
                                       $urandom_range(3), 0);
    repeat (3) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    chk_flags();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
